// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : vend_controller
// Description : Coin-operated vending controller: credit accumulation,
//               four-product dispense, nickel change payout.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_controller #(
    parameter int P0        = 15,
    parameter int P1        = 20,
    parameter int P2        = 25,
    parameter int P3        = 30,
    parameter int CAP       = 95,
    parameter int DISP_HOLD = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       clk_en,
    input  logic [2:0] coin,
    input  logic [3:0] sw,
    input  logic       ret,
    input  logic       chg_ack,
    output logic [3:0] vend,
    output logic [6:0] credit,
    output logic       deny,
    output logic       coin_rej,
    output logic       chg_req,
    output logic       busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_VEND     = 2'd1;
    localparam logic [1:0] c_CHANGE   = 2'd2;
    localparam logic [1:0] c_WAIT_REL = 2'd3;

    localparam int                  c_HOLD_W    = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(DISP_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [7:0]          c_CAP       = 8'(CAP);
    localparam logic [6:0]          c_NICKEL    = 7'd5;

    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [6:0]          r_credit;
    logic [3:0]          r_vend;
    logic                r_deny;
    logic                r_coin_rej;
    logic                r_chg_req;
    logic                r_busy;

    logic [7:0] w_credit8;
    logic [7:0] w_coin_val;
    logic [7:0] w_price;
    logic [6:0] w_credit_next;
    logic       w_idle;
    logic       w_coin_onehot;
    logic       w_sw_onehot;
    logic       w_coin_ok;
    logic       w_coin_rej;
    logic       w_buy;
    logic       w_deny;
    logic       w_ret_go;

    assign w_credit8 = {1'b0, r_credit};
    assign w_idle    = (r_state == c_IDLE);

    always_comb begin
        w_coin_val    = 8'd0;
        w_coin_onehot = 1'b1;
        case (coin)
            3'b001:  w_coin_val = 8'd5;
            3'b010:  w_coin_val = 8'd10;
            3'b100:  w_coin_val = 8'd25;
            default: w_coin_onehot = 1'b0;
        endcase
    end

    always_comb begin
        w_price     = 8'd0;
        w_sw_onehot = 1'b1;
        case (sw)
            4'b0001: w_price = 8'(P0);
            4'b0010: w_price = 8'(P1);
            4'b0100: w_price = 8'(P2);
            4'b1000: w_price = 8'(P3);
            default: w_sw_onehot = 1'b0;
        endcase
    end

    // A coincident purchase is judged on the credit held before the coin lands.
    assign w_coin_ok     = w_idle & w_coin_onehot & ((w_credit8 + w_coin_val) <= c_CAP);
    assign w_coin_rej    = (coin != 3'b000) & ~w_coin_ok;
    assign w_buy         = w_idle & w_sw_onehot & (w_credit8 >= w_price);
    assign w_deny        = w_idle & (sw != 4'b0000) & ~w_buy;
    assign w_ret_go      = w_idle & ret & (coin == 3'b000) & ~w_buy & (r_credit != 7'd0);
    assign w_credit_next = 7'(w_credit8 + (w_coin_ok ? w_coin_val : 8'd0)
                                        - (w_buy ? w_price : 8'd0));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= c_IDLE;
            r_hold     <= '0;
            r_credit   <= '0;
            r_vend     <= '0;
            r_deny     <= 1'b0;
            r_coin_rej <= 1'b0;
            r_chg_req  <= 1'b0;
            r_busy     <= 1'b0;
        end else if (clk_en) begin
            r_coin_rej <= w_coin_rej;
            r_deny     <= w_deny;
            case (r_state)
                c_IDLE: begin
                    r_credit <= w_credit_next;
                    if (w_buy) begin
                        r_vend  <= sw;
                        r_hold  <= c_HOLD_INIT;
                        r_state <= c_VEND;
                        r_busy  <= 1'b1;
                    end else if (w_ret_go) begin
                        r_chg_req <= 1'b1;
                        r_state   <= c_CHANGE;
                        r_busy    <= 1'b1;
                    end
                end
                c_VEND: begin
                    if (r_hold == '0) begin
                        r_vend <= '0;
                        if (r_credit != 7'd0) begin
                            r_chg_req <= 1'b1;
                            r_state   <= c_CHANGE;
                        end else begin
                            r_state <= c_WAIT_REL;
                        end
                    end else begin
                        r_hold <= r_hold - c_HOLD_ONE;
                    end
                end
                c_CHANGE: begin
                    // Each acknowledged nickel drops the request for one enabled cycle.
                    if (r_chg_req) begin
                        if (chg_ack) begin
                            r_chg_req <= 1'b0;
                            if (r_credit <= c_NICKEL) begin
                                r_credit <= '0;
                                r_state  <= c_WAIT_REL;
                            end else begin
                                r_credit <= r_credit - c_NICKEL;
                            end
                        end
                    end else begin
                        r_chg_req <= 1'b1;
                    end
                end
                c_WAIT_REL: begin
                    if (sw == 4'b0000) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_vend    <= '0;
                    r_chg_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign vend     = r_vend;
    assign credit   = r_credit;
    assign deny     = r_deny;
    assign coin_rej = r_coin_rej;
    assign chg_req  = r_chg_req;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_controller
// Description : Self-checking bench for vend_controller with a transaction-level
//               reference model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

    localparam int P0        = 15;
    localparam int P1        = 20;
    localparam int P2        = 25;
    localparam int P3        = 30;
    localparam int CAP       = 95;
    localparam int DISP_HOLD = 4;

    logic       clk     = 1'b0;
    logic       clr     = 1'b0;
    logic       clk_en  = 1'b1;
    logic [2:0] coin    = 3'b000;
    logic [3:0] sw      = 4'b0000;
    logic       ret     = 1'b0;
    logic       chg_ack = 1'b0;
    logic [3:0] vend;
    logic [6:0] credit;
    logic       deny;
    logic       coin_rej;
    logic       chg_req;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: what a customer would observe, tracked as money and phases.
    int         m_credit   = 0;
    int         m_show     = 0;
    logic [3:0] m_vend     = 4'b0000;
    bit         m_deny     = 1'b0;
    bit         m_coin_rej = 1'b0;
    bit         m_chg_req  = 1'b0;
    bit         m_busy     = 1'b0;
    bit         m_paying   = 1'b0;
    bit         m_release  = 1'b0;

    vend_controller #(
        .P0(P0), .P1(P1), .P2(P2), .P3(P3), .CAP(CAP), .DISP_HOLD(DISP_HOLD)
    ) dut (
        .clk(clk), .clr(clr), .clk_en(clk_en), .coin(coin), .sw(sw), .ret(ret),
        .chg_ack(chg_ack), .vend(vend), .credit(credit), .deny(deny),
        .coin_rej(coin_rej), .chg_req(chg_req), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int coin_cents(input logic [2:0] c);
        if (c == 3'b001) return 5;
        if (c == 3'b010) return 10;
        if (c == 3'b100) return 25;
        return 0;
    endfunction

    function automatic int item_price(input logic [3:0] s);
        if (s == 4'b0001) return P0;
        if (s == 4'b0010) return P1;
        if (s == 4'b0100) return P2;
        if (s == 4'b1000) return P3;
        return -1;
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_credit = 0; m_show = 0; m_vend = 4'b0000; m_deny = 0; m_coin_rej = 0;
            m_chg_req = 0; m_busy = 0; m_paying = 0; m_release = 0;
        end else if (clk_en) begin
            int  cv;
            int  price;
            bit  shopping;
            bit  coin_ok;
            bit  buy;
            bit  refund;
            shopping   = !m_busy;
            cv         = coin_cents(coin);
            price      = item_price(sw);
            coin_ok    = shopping && cv > 0 && (m_credit + cv <= CAP);
            buy        = shopping && price >= 0 && m_credit >= price;
            refund     = shopping && !buy && ret && coin == 3'b000 && m_credit > 0;
            m_coin_rej = (coin != 3'b000) && !coin_ok;
            m_deny     = shopping && sw != 4'b0000 && !buy;
            if (shopping) begin
                m_credit = m_credit + (coin_ok ? cv : 0) - (buy ? price : 0);
                if (buy) begin
                    m_vend = sw; m_show = DISP_HOLD; m_busy = 1;
                end else if (refund) begin
                    m_paying = 1; m_chg_req = 1; m_busy = 1;
                end
            end else if (m_show > 0) begin
                m_show = m_show - 1;
                if (m_show == 0) begin
                    m_vend = 4'b0000;
                    if (m_credit > 0) begin m_paying = 1; m_chg_req = 1; end
                    else m_release = 1;
                end
            end else if (m_paying) begin
                if (!m_chg_req) m_chg_req = 1;
                else if (chg_ack) begin
                    m_chg_req = 0;
                    m_credit  = m_credit - 5;
                    if (m_credit <= 0) begin m_credit = 0; m_paying = 0; m_release = 1; end
                end
            end else if (m_release) begin
                if (sw == 4'b0000) begin m_release = 0; m_busy = 0; end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (vend !== m_vend || credit !== 7'(m_credit) || deny !== m_deny ||
            coin_rej !== m_coin_rej || chg_req !== m_chg_req || busy !== m_busy) begin
            errors++;
            $display("FAIL model_cmp at %0t: got vend=%b credit=%0d deny=%b rej=%b req=%b busy=%b expected vend=%b credit=%0d deny=%b rej=%b req=%b busy=%b",
                     $time, vend, credit, deny, coin_rej, chg_req, busy,
                     m_vend, m_credit, m_deny, m_coin_rej, m_chg_req, m_busy);
        end
    end

    // Apply one enabled edge; coin, ret and chg_ack are single-cycle pulses, sw is a level.
    task automatic cyc(input logic [2:0] c, input logic [3:0] s, input logic r, input logic a);
        coin = c; sw = s; ret = r; chg_ack = a;
        @(posedge clk); #1;
        coin = 3'b000; ret = 1'b0; chg_ack = 1'b0;
    endtask

    task automatic wait_req(input logic [3:0] s);
        int n;
        n = 0;
        while (!chg_req && n < 10) begin
            cyc(3'b000, s, 1'b0, 1'b0);
            n++;
        end
        check("chg_req_wait", int'(chg_req), 1);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_vend", int'(vend), 0);
        clr = 1'b1;

        // Insufficient credit, then release.
        cyc(3'b001, 4'b0000, 0, 0);
        check("a_credit5", int'(credit), 5);
        cyc(3'b000, 4'b0001, 0, 0);
        check("a_deny", int'(deny), 1);
        check("a_deny_credit", int'(credit), 5);
        check("a_deny_vend", int'(vend), 0);
        cyc(3'b000, 4'b0000, 0, 0);
        check("a_deny_clear", int'(deny), 0);

        // Exact-price purchase and held-switch release.
        cyc(3'b010, 4'b0000, 0, 0);
        check("b_credit15", int'(credit), 15);
        cyc(3'b000, 4'b0001, 0, 0);
        check("b_credit0", int'(credit), 0);
        check("b_vend", int'(vend), 1);
        for (int i = 0; i < DISP_HOLD - 1; i++) begin
            cyc(3'b000, 4'b0001, 0, 0);
            check("b_vend_held", int'(vend), 1);
        end
        cyc(3'b000, 4'b0001, 0, 0);
        check("b_vend_off", int'(vend), 0);
        repeat (3) cyc(3'b000, 4'b0001, 0, 0);
        check("b_wait_rel", int'(busy), 1);
        check("b_no_revend", int'(vend), 0);
        cyc(3'b000, 4'b0000, 0, 0);
        check("b_idle", int'(busy), 0);

        // Purchase with change.
        cyc(3'b100, 4'b0000, 0, 0);
        cyc(3'b100, 4'b0000, 0, 0);
        check("c_credit50", int'(credit), 50);
        cyc(3'b000, 4'b0100, 0, 0);
        check("c_vend", int'(vend), 4);
        check("c_credit25", int'(credit), 25);
        for (int i = 0; i < 5; i++) begin
            wait_req(4'b0100);
            cyc(3'b000, 4'b0100, 0, 1);
            check("c_nickel_credit", int'(credit), 20 - 5 * i);
            check("c_req_drop", int'(chg_req), 0);
        end
        check("c_busy_held", int'(busy), 1);
        cyc(3'b000, 4'b0000, 0, 0);
        check("c_idle", int'(busy), 0);

        // Credit cap and coins while dispensing; reset mid-dispense.
        cyc(3'b100, 4'b0000, 0, 0);
        cyc(3'b100, 4'b0000, 0, 0);
        cyc(3'b100, 4'b0000, 0, 0);
        cyc(3'b010, 4'b0000, 0, 0);
        cyc(3'b010, 4'b0000, 0, 0);
        check("d_credit95", int'(credit), 95);
        cyc(3'b001, 4'b0000, 0, 0);
        check("d_cap_rej", int'(coin_rej), 1);
        check("d_cap_credit", int'(credit), 95);
        cyc(3'b000, 4'b0000, 0, 0);
        check("d_rej_pulse", int'(coin_rej), 0);
        cyc(3'b000, 4'b1000, 0, 0);
        check("d_credit65", int'(credit), 65);
        cyc(3'b001, 4'b1000, 0, 0);
        check("d_vend_rej", int'(coin_rej), 1);
        check("d_vend_credit", int'(credit), 65);
        #2 clr = 1'b0;
        #1;
        check("d_rst_credit", int'(credit), 0);
        check("d_rst_vend", int'(vend), 0);
        @(posedge clk); #1;
        clr = 1'b1; sw = 4'b0000;

        // Coin return interrupted by reset.
        cyc(3'b100, 4'b0000, 0, 0);
        cyc(3'b001, 4'b0000, 0, 0);
        check("e_credit30", int'(credit), 30);
        cyc(3'b000, 4'b0000, 1, 0);
        check("e_req", int'(chg_req), 1);
        for (int i = 0; i < 2; i++) begin
            wait_req(4'b0000);
            cyc(3'b000, 4'b0000, 0, 1);
            check("e_nickel_credit", int'(credit), 25 - 5 * i);
        end
        wait_req(4'b0000);
        #2 clr = 1'b0;
        #1;
        check("e_rst_credit", int'(credit), 0);
        check("e_rst_req", int'(chg_req), 0);
        check("e_rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        clr = 1'b1;
        cyc(3'b000, 4'b0000, 0, 1);
        check("e_after_credit", int'(credit), 0);
        check("e_after_busy", int'(busy), 0);

        // Clock enable held low.
        cyc(3'b010, 4'b0000, 0, 0);
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            coin = (i % 2 == 0) ? 3'b001 : 3'b100;
            @(posedge clk); #1;
        end
        coin = 3'b000;
        check("f_credit", int'(credit), 10);
        check("f_rej", int'(coin_rej), 0);
        check("f_busy", int'(busy), 0);
        clk_en = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            clk_en = ($urandom_range(0, 99) < 85);
            clr    = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 3) == 0) coin = 3'($urandom_range(1, 7));
                else coin = 3'(1 << $urandom_range(0, 2));
            end else begin
                coin = 3'b000;
            end
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, 9);
                if (k < 4) sw = 4'b0000;
                else if (k < 8) sw = 4'(1 << $urandom_range(0, 3));
                else sw = 4'($urandom_range(0, 15));
            end
            ret     = ($urandom_range(0, 19) == 0);
            chg_ack = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        clr = 1'b1; clk_en = 1'b1;
        coin = 3'b000; sw = 4'b0000; ret = 1'b0; chg_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter P0, default 15, price in cents of product 0 (sw[0]).
REQ-002 SHALL have parameter P1, default 20, price of product 1; P2, default 25, price of product 2; P3, default 30, price of product 3.
REQ-003 SHALL have parameter CAP, default 95, maximum credit in cents (multiple of 5, at most 127).
REQ-004 SHALL have parameter DISP_HOLD, default 4, number of enabled cycles a vend output is held.
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port clk_en  input  1  qualifier; state advances and inputs are sampled only on edges where clk_en=1.
REQ-008 SHALL have port coin  input  3  one-hot coin pulse: [0]=5c, [1]=10c, [2]=25c.
REQ-009 SHALL have port sw  input  4  product request level, one-hot, [0]=product 0.
REQ-010 SHALL have port ret  input  1  coin-return request pulse.
REQ-011 SHALL have port chg_ack  input  1  change hopper acknowledge: one nickel paid.
REQ-012 SHALL have port vend  output  4  one-hot dispense, drives leds.
REQ-013 SHALL have port credit  output  7  current credit in cents, binary, for display.
REQ-014 SHALL have port deny  output  1  request refused: insufficient credit or invalid select.
REQ-015 SHALL have port coin_rej  output  1  one-enabled-cycle coin reject pulse.
REQ-016 SHALL have port chg_req  output  1  change hopper request.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, VEND, CHANGE and WAIT_REL; all outputs registered.
REQ-019 SHALL, in IDLE, on a one-hot coin, add its value to credit next enabled cycle if the sum is at most CAP; otherwise credit is unchanged and coin_rej=1 for one enabled cycle.
REQ-020 SHALL treat a multi-hot coin, or any coin outside IDLE, as rejected: coin_rej pulses and credit is unchanged.
REQ-021 SHALL, in IDLE, with one-hot sw and credit >= price: subtract price, set vend=sw, and enter VEND, all on the same enabled edge.
REQ-022 SHALL, in IDLE, with one-hot sw and credit < price, or with multi-hot sw: hold deny=1 while the condition persists, leaving credit and state unchanged.
REQ-023 SHALL keep deny=0 in all other cases.
REQ-024 SHALL apply priority on the same edge: coin, then sw purchase, then ret.
REQ-025 SHALL evaluate a purchase coincident with an accepted coin against the pre-coin credit.
REQ-026 SHALL, in IDLE on ret with credit>0, enter CHANGE; ret with credit=0 is ignored.
REQ-027 SHALL, in VEND, hold vend for exactly DISP_HOLD enabled cycles, then clear vend and enter CHANGE if credit>0, else WAIT_REL.
REQ-028 SHALL, in CHANGE, assert chg_req and hold it until chg_ack=1 is sampled; credit then decreases by 5 and chg_req drops for at least one enabled cycle before it is reasserted.
REQ-029 SHALL ignore chg_ack while chg_req=0.
REQ-030 SHALL leave CHANGE for WAIT_REL on the edge that credit reaches 0.
REQ-031 SHALL, in WAIT_REL, return to IDLE on the first enabled cycle with sw=0; held sw never re-vends.
REQ-032 SHALL never let credit exceed CAP or underflow below 0.

Reset
REQ-033 SHALL, while clr=0, immediately force state IDLE and drive credit=0, vend=0, deny=0, coin_rej=0, chg_req=0, busy=0, and clear the hold counter, independent of clk and clk_en.
REQ-034 SHALL, on reset asserted mid-VEND or mid-CHANGE, discard credit with no pending change paid.
REQ-035 SHALL begin operation on the first enabled edge after clr returns to 1.

Verification
REQ-036 SHALL verify: 5c, then sw=0001 -> deny=1, credit=5, vend=0; sw=0000 -> deny=0.
REQ-037 SHALL verify: 10c, then sw=0001 -> credit=0, vend=0001 for 4 enabled cycles; held sw stays in WAIT_REL, IDLE once sw=0000.
REQ-038 SHALL verify: 25c twice, sw=0100 -> vend=0100, credit=25, then 5 chg_req/chg_ack handshakes, credit 25->0, busy low after sw release.
REQ-039 SHALL verify: credit 95 plus a 5c coin -> coin_rej pulse, credit=95; a coin during VEND -> coin_rej, credit unchanged.
REQ-040 SHALL verify: credit 30, ret -> 6 nickel handshakes; clr=0 during the third handshake -> credit=0, chg_req=0 immediately, IDLE.
REQ-041 SHALL verify: clk_en held low for 10 cycles with coin pulses present -> no state or credit change.
